// File: rtl/aemb2_fetch_if.sv
// Instruction bus bundle between the fetch stage and its slave.
// Fetch is the master; the slave answers with ack/err and data.
interface aemb2_fetch_if;
  logic [31:2] iwb_adr_o;
  logic        iwb_stb_o;
  logic        iwb_ack_i;
  logic        iwb_err_i;
  logic [31:0] iwb_dat_i;

  modport master (
    output iwb_adr_o,
    output iwb_stb_o,
    input  iwb_ack_i,
    input  iwb_err_i,
    input  iwb_dat_i
  );

  modport slave (
    input  iwb_adr_o,
    input  iwb_stb_o,
    output iwb_ack_i,
    output iwb_err_i,
    output iwb_dat_i
  );
endinterface

// File: rtl/aemb2_fetch.sv
// Instruction fetch stage: one outstanding bus read, one held word,
// and per-thread PCs that alternate by phase when threading is on.
module aemb2_fetch #(
  parameter int          AEMB_HTX = 1,
  parameter logic [29:0] AEMB_RST = 30'h0
) (
  input  logic         gclk,
  input  logic         grst,
  aemb2_fetch_if.master iwb,
  input  logic         dena,
  input  logic [1:0]   bra_ex,
  input  logic [31:2]  bpc_ex,
  output logic [31:0]  ich_dat,
  output logic [31:2]  rpc_if,
  output logic         iena,
  output logic         gpha,
  output logic         exc_iwb
);

  localparam logic [31:0] NOP = 32'h8000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      st_q, st_d;
  logic        run_q;
  logic [29:0] pc0_q, pc0_d;
  logic [29:0] pc1_q, pc1_d;
  logic        gpha_q, gpha_d;
  logic [31:0] ich_q, ich_d;
  logic [29:0] rpc_q, rpc_d;
  logic        exc_q, exc_d;
  logic [29:0] fpc;
  logic [29:0] next_pc;
  logic        unused_bra;

  // The delay-slot flag is decode's concern; fetch only redirects.
  assign unused_bra = bra_ex[0];

  assign fpc = ((AEMB_HTX != 0) && gpha_q) ? pc1_q : pc0_q;

  assign next_pc = bra_ex[1] ? bpc_ex : rpc_q + 30'd1;

  assign iwb.iwb_adr_o = fpc;
  assign iwb.iwb_stb_o = run_q && (st_q == FETCH);

  assign ich_dat = ich_q;
  assign rpc_if  = rpc_q;
  assign exc_iwb = exc_q;
  assign gpha    = gpha_q;
  assign iena    = (st_q == HOLD);

  // Strobe enable: first bus request one edge after reset release,
  // and a reset mid-cycle kills the strobe so late acks are ignored.
  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) run_q <= 1'b0;
    else       run_q <= 1'b1;
  end

  // Next-state: latch the bus word on termination, advance PC on consume.
  always_comb begin
    st_d   = st_q;
    pc0_d  = pc0_q;
    pc1_d  = pc1_q;
    gpha_d = gpha_q;
    ich_d  = ich_q;
    rpc_d  = rpc_q;
    exc_d  = exc_q;
    unique case (st_q)
      FETCH: begin
        if (run_q && (iwb.iwb_err_i || iwb.iwb_ack_i)) begin
          st_d  = HOLD;
          ich_d = iwb.iwb_err_i ? NOP : iwb.iwb_dat_i;
          rpc_d = fpc;
          exc_d = iwb.iwb_err_i;
        end
      end
      HOLD: begin
        if (dena) begin
          st_d = FETCH;
          if ((AEMB_HTX != 0) && gpha_q) pc1_d = next_pc;
          else                           pc0_d = next_pc;
          if (AEMB_HTX != 0) gpha_d = ~gpha_q;
        end
      end
      default: begin
        st_d = FETCH;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      st_q   <= FETCH;
      pc0_q  <= AEMB_RST;
      pc1_q  <= AEMB_RST;
      gpha_q <= 1'b0;
      ich_q  <= NOP;
      rpc_q  <= AEMB_RST;
      exc_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      pc0_q  <= pc0_d;
      pc1_q  <= pc1_d;
      gpha_q <= gpha_d;
      ich_q  <= ich_d;
      rpc_q  <= rpc_d;
      exc_q  <= exc_d;
    end
  end

endmodule

// File: doc/aemb2_fetch.md
AEMB2_FETCH -- requirements
Module: aemb2_fetch

Interface
REQ-001 SHALL have parameter AEMB_HTX, default 1, meaning two hardware threads alternate by phase; 0 means a single thread.
REQ-002 SHALL have parameter AEMB_RST, default 30'h0, the reset word address for every thread PC.
REQ-003 SHALL have port gclk, input, 1 bit: the single core clock; all state changes on its rising edge.
REQ-004 SHALL have port grst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port iwb_adr_o, output, [31:2]: instruction bus word address.
REQ-006 SHALL have port iwb_stb_o, output, 1 bit: instruction bus strobe/cycle.
REQ-007 SHALL have port iwb_ack_i, input, 1 bit: bus acknowledge.
REQ-008 SHALL have port iwb_err_i, input, 1 bit: bus error termination.
REQ-009 SHALL have port iwb_dat_i, input, 32 bits: instruction read data.
REQ-010 SHALL have port dena, input, 1 bit: pipeline advance; the decode stage consumes ich_dat when dena=1 and iena=1.
REQ-011 SHALL have port bra_ex, input, 2 bits: bit1 = branch taken in EX, bit0 = delay slot present; sampled only when dena=1.
REQ-012 SHALL have port bpc_ex, input, [31:2]: branch target word address.
REQ-013 SHALL have port ich_dat, output, 32 bits: held instruction word for decode.
REQ-014 SHALL have port rpc_if, output, [31:2]: word address of the instruction in ich_dat.
REQ-015 SHALL have port iena, output, 1 bit: ich_dat valid.
REQ-016 SHALL have port gpha, output, 1 bit: thread phase of the instruction in ich_dat; it is constant 0 when AEMB_HTX=0.
REQ-017 SHALL have port exc_iwb, output, 1 bit: the instruction in ich_dat came from a bus error.

Function
REQ-018 SHALL implement a 2-state FSM:
- FETCH: iwb_stb_o=1, iena=0.
- HOLD: iwb_stb_o=0, iena=1.
REQ-019 In FETCH, iwb_adr_o SHALL equal the fetch PC of the current phase and SHALL remain stable until termination.
- At most one request is outstanding.
- stb is never dropped before ack or err.
REQ-020 On iwb_ack_i=1 in FETCH:
- ich_dat <= iwb_dat_i, rpc_if <= iwb_adr_o, exc_iwb <= 0.
- Go to HOLD.
- Latency is 1 clock from ack to iena=1.
REQ-021 On iwb_err_i=1 in FETCH (err has priority over ack):
- ich_dat <= 32'h80000000 (NOP), rpc_if <= iwb_adr_o, exc_iwb <= 1.
- Go to HOLD.
REQ-022 In HOLD with dena=0, all outputs SHALL hold.
REQ-023 In HOLD with dena=1 (consume), the block SHALL:
- update the PC of the current thread to next_pc;
- toggle gpha if AEMB_HTX=1;
- go to FETCH.
- The next fetch address is the PC of the new phase, so with AEMB_HTX=0 it is next_pc itself.
REQ-024 next_pc SHALL be bpc_ex when bra_ex[1]=1 at consume, else rpc_if+1.
- A redirect applies to the current thread; the EX instruction is two issues back, which is the same phase.
REQ-025 PC arithmetic SHALL be 30-bit modulo: 30'h3FFFFFFF+1 = 30'h0.
REQ-026 With bra_ex[1]=1 and bra_ex[0]=0, the block SHALL still hand over the held instruction.
- Squashing it is the decode stage's job (hzd_bpc).
- Fetch only redirects.
REQ-027 bra_ex and bpc_ex SHALL be ignored when dena=0 or the FSM is in FETCH.
REQ-028 The inactive thread PC SHALL change only when that thread consumes.

Reset
REQ-029 While grst=0, the block SHALL asynchronously force:
- FSM=FETCH, both PCs=AEMB_RST, gpha=0;
- iwb_stb_o=0, iwb_adr_o=AEMB_RST;
- ich_dat=32'h80000000, rpc_if=AEMB_RST, iena=0, exc_iwb=0.
REQ-030 iwb_stb_o SHALL first assert on the first rising edge after grst deasserts.
REQ-031 Reset during an outstanding bus cycle SHALL drop iwb_stb_o immediately and discard any later ack.

Verification
REQ-032 Reset release, zero-wait slave, dena=1, AEMB_HTX=0:
- Addresses are 0,1,2,3.
- iena alternates 0/1.
- rpc_if follows each fetched address.
REQ-033 AEMB_HTX=1, dena=1, branch at thread-0 word 5 with bra_ex=2'b10 and bpc_ex=30'h40 at consume:
- Thread 1 continues sequentially.
- Thread 0's next fetch is 30'h40.
- gpha toggles on every consume.
REQ-034 Slave inserts 3 wait states:
- stb and adr stay stable for 4 cycles.
- iena rises 1 cycle after ack.
REQ-035 iwb_err_i at address 30'h10:
- ich_dat=32'h80000000, exc_iwb=1, rpc_if=30'h10.
- Next fetch is 30'h11.
- exc_iwb=0 after the following ack.
REQ-036 HOLD with dena=0 for 5 cycles, and bra_ex=2'b11 toggled during them:
- No outputs change.
- The branch is ignored.
- Consume then fetches rpc_if+1.
REQ-037 PC at 30'h3FFFFFFF, consume: next fetch address is 30'h0.
REQ-038 grst pulsed low mid-wait-state: stb=0 asynchronously, and a late ack is not latched.
